oversampled_bit_receiver: RTL and testbench
===========================================

Name: oversampled_bit_receiver

Overview:
- Parametrised successor to the single-run bit validator in the optical receive path.
- Recovers a bit stream from an asynchronous optical input oversampled at the system clock, e.g. 60 MHz sampling a 6.144 MHz line gives about 10 samples per bit.
- Emits one bit per SAMPLES_PER_BIT samples of a run. This handles consecutive identical bits.
- Rounds run tails, flags glitch runs and assembles bits LSB-first into WORD_WIDTH words for the downstream framer.

Parameters:
- SAMPLES_PER_BIT, 10, nominal samples per line bit. Must be >= 2.
- HALF_THRESH, SAMPLES_PER_BIT/2, minimum residual samples at a run end that count as one more bit.
- WORD_WIDTH, 8, bits per assembled word. Must be >= 2.
- CNT_WIDTH, 8, width of the phase counter. Must hold SAMPLES_PER_BIT.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- din  input  1  raw optical sample, asynchronous to clk
- word_clr  input  1  synchronous word-alignment clear
- bit_out  output  1  recovered bit, valid when bit_valid=1
- bit_valid  output  1  one-cycle pulse per recovered bit
- word_out  output  WORD_WIDTH  last completed word, bit 0 = first received
- word_valid  output  1  one-cycle pulse when word_out updates
- glitch  output  1  one-cycle pulse when a short run is discarded

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high. All registers are cleared only on a clk edge with rst=1.
- Reset values:
  - Outputs: bit_out=0, bit_valid=0, word_out=0, word_valid=0, glitch=0.
  - Internal state: sync flops=0, cur=0, ph=0, emitted=1, idx=0, shift register=0.
  - emitted=1 suppresses a false glitch on the first transition.
- Input path: 2-flop synchronizer. The core consumes synchronized sample s each cycle.
- Latency: a din value stable before edge t is consumed at edge t+2. Outputs caused by it are visible after edge t+2, i.e. 3 edges including the capture edge.
- Core rules, per cycle, for sample s:
  - s==cur and ph+1==SAMPLES_PER_BIT: emit cur, ph<=0, emitted<=1.
  - s==cur otherwise: ph<=ph+1.
  - s!=cur (run end):
    - If ph>=HALF_THRESH: emit cur (tail bit).
    - Else if emitted==0: pulse glitch and emit nothing.
    - Else (emitted==1, ph<HALF_THRESH): emit nothing and do not pulse glitch.
    - In all three cases: cur<=s, ph<=1, emitted<=0.
- Emit means bit_out<=value and bit_valid<=1 for exactly one cycle. With no emit, bit_valid<=0 and bit_out holds.
- At most one emit per cycle; a run-end emit never coincides with a count emit.
- Run-length result: a run of L samples yields floor(L/SPB) bits, plus 1 if (L mod SPB)>=HALF_THRESH. A run with zero bits is a glitch.
- Word assembly:
  - An emitted bit is written to shift position idx. idx increments.
  - When idx==WORD_WIDTH-1 the completed word is loaded into word_out and idx<=0.
  - word_valid pulses in the same cycle as that word's last bit_valid.
  - word_out holds its value between word_valid pulses.
- Glitch clears idx to 0: the partial word is dropped and word_out is unchanged.
- word_clr=1 clears idx to 0. If an emit occurs in the same cycle, the emitted bit becomes bit 0 of the new word (idx<=1) and no word_valid is produced.
- Reset mid-operation: the partial word, the run and the counters are discarded. No output pulses occur in the reset cycle or the cycle after.
- A constant input emits a bit every SAMPLES_PER_BIT cycles indefinitely. There is no idle detection.

Test Plan (SPB=10, HALF=5, WORD_WIDTH=8):
- Reset with din toggling -> all outputs 0 during reset and on the cycle after release. No glitch on the first transition after release.
- din low from reset, then 10 high samples, then low -> exactly one bit_valid with bit_out=1 on the 10th high sample (+2 cycles). No tail bit and no glitch at the falling edge.
- High runs of 27, 24 and 5 samples between long low runs -> 3, 2 and 1 ones respectively. The tail bit appears on the cycle consuming the first low sample. The 5-sample run raises no glitch.
- 3-sample high run inside a low stream after 4 bits of a word -> glitch=1 for one cycle, no bit from that run, idx reset. The next 8 bits form a complete word.
- Byte 0xA5 sent LSB-first at 10 samples/bit (bits 1,0,1,0,0,1,0,1) -> 8 bit_valid pulses. word_out=0xA5 with word_valid on the 8th pulse.
- word_clr asserted in the same cycle as the 3rd bit's emit, then 7 more bits -> no word_valid until 8 bits from the cleared point. The 3rd bit is word_out[0].

Source files
------------

// File: rtl/oversampled_bit_receiver.sv
// Recovers line bits from an oversampled asynchronous input by measuring run lengths,
// rounding run tails, flagging glitch runs and packing bits LSB-first into words.
module oversampled_bit_receiver #(
    parameter int SAMPLES_PER_BIT = 10,
    parameter int HALF_THRESH     = SAMPLES_PER_BIT / 2,
    parameter int WORD_WIDTH      = 8,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  din,
    input  logic                  word_clr,
    output logic                  bit_out,
    output logic                  bit_valid,
    output logic [WORD_WIDTH-1:0] word_out,
    output logic                  word_valid,
    output logic                  glitch
);

    localparam int IDX_W = $clog2(WORD_WIDTH);

    localparam logic [CNT_WIDTH-1:0] SPB_LAST = CNT_WIDTH'(SAMPLES_PER_BIT - 1);
    localparam logic [CNT_WIDTH-1:0] HALF_C   = CNT_WIDTH'(HALF_THRESH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(WORD_WIDTH - 1);
    localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);

    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic                  cur_q, cur_d;
    logic [CNT_WIDTH-1:0]  ph_q, ph_d;
    logic                  emitted_q, emitted_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic                  bit_out_q, bit_out_d;
    logic                  bit_valid_q, bit_valid_d;
    logic [WORD_WIDTH-1:0] word_out_q, word_out_d;
    logic                  word_valid_q, word_valid_d;
    logic                  glitch_q, glitch_d;
    logic                  emit;

    always_comb begin
        sync1_d      = din;
        sync2_d      = sync1_q;
        cur_d        = cur_q;
        ph_d         = ph_q;
        emitted_d    = emitted_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        bit_out_d    = bit_out_q;
        bit_valid_d  = 1'b0;
        word_out_d   = word_out_q;
        word_valid_d = 1'b0;
        glitch_d     = 1'b0;
        emit         = 1'b0;

        // ph counts samples since the last emit in this run, so at a run end it is the tail length
        if (sync2_q == cur_q) begin
            if (ph_q == SPB_LAST) begin
                emit      = 1'b1;
                ph_d      = '0;
                emitted_d = 1'b1;
            end else begin
                ph_d = ph_q + CNT_ONE;
            end
        end else begin
            if (ph_q >= HALF_C) begin
                emit = 1'b1;
            end else if (!emitted_q) begin
                glitch_d = 1'b1;
            end
            cur_d     = sync2_q;
            ph_d      = CNT_ONE;
            emitted_d = 1'b0;
        end

        if (emit) begin
            bit_out_d   = cur_q;
            bit_valid_d = 1'b1;
        end

        // A clear coinciding with an emit starts the new word with that bit
        if (emit) begin
            if (word_clr) begin
                shift_d[0] = cur_q;
                idx_d      = IDX_ONE;
            end else begin
                shift_d[idx_q] = cur_q;
                if (idx_q == IDX_LAST) begin
                    word_out_d   = shift_d;
                    word_valid_d = 1'b1;
                    idx_d        = '0;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
        end else if (word_clr || glitch_d) begin
            idx_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cur_q        <= 1'b0;
            ph_q         <= '0;
            emitted_q    <= 1'b1;
            idx_q        <= '0;
            shift_q      <= '0;
            bit_out_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            glitch_q     <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            cur_q        <= cur_d;
            ph_q         <= ph_d;
            emitted_q    <= emitted_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            bit_out_q    <= bit_out_d;
            bit_valid_q  <= bit_valid_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            glitch_q     <= glitch_d;
        end
    end

    assign bit_out    = bit_out_q;
    assign bit_valid  = bit_valid_q;
    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;
    assign glitch     = glitch_q;

endmodule

// File: tb/tb_oversampled_bit_receiver.sv
// Directed bench for oversampled_bit_receiver: a run-length reference predicts every
// recovered bit and word, and a scoreboard compares them against the DUT pulses.
module tb_oversampled_bit_receiver;

    localparam int SPB  = 10;
    localparam int HALF = 5;
    localparam int WW   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          din = 1'b0;
    logic          word_clr = 1'b0;
    logic          bit_out;
    logic          bit_valid;
    logic [WW-1:0] word_out;
    logic          word_valid;
    logic          glitch;

    oversampled_bit_receiver #(
        .SAMPLES_PER_BIT(SPB),
        .HALF_THRESH(HALF),
        .WORD_WIDTH(WW),
        .CNT_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .word_clr(word_clr),
        .bit_out(bit_out),
        .bit_valid(bit_valid),
        .word_out(word_out),
        .word_valid(word_valid),
        .glitch(glitch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          b;
        logic          wv;
    } ev_t;

    ev_t sb_q[$];

    int assertsEvaluated = 0;
    int failures = 0;
    int onesSeen = 0;
    int glitchSeen = 0;
    int wordsSeen = 0;

    // reference state: delay line, current run, word being assembled
    logic          mP1 = 1'b0;
    logic          mP2 = 1'b0;
    logic          mVal = 1'b0;
    int            mLen = 0;
    bit            mFirst = 1'b1;
    int            mWcount = 0;
    logic [WW-1:0] mWbuf = '0;
    logic [WW-1:0] mLastWord = '0;
    logic          mExpGlitch = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertsEvaluated++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // reference behaviour at one clock edge, expressed in run lengths
    function automatic void modelEdge(input logic d, input logic clr, input logic r);
        logic s;
        logic emitV;
        logic emitB;
        logic wordDone;
        ev_t  e;
        emitV      = 1'b0;
        emitB      = 1'b0;
        wordDone   = 1'b0;
        mExpGlitch = 1'b0;
        if (r) begin
            mP1 = 1'b0; mP2 = 1'b0; mVal = 1'b0; mLen = 0; mFirst = 1'b1;
            mWcount = 0; mWbuf = '0; mLastWord = '0;
            sb_q.delete();
            return;
        end
        s   = mP2;
        mP2 = mP1;
        mP1 = d;
        if (s == mVal) begin
            mLen++;
            if (mLen % SPB == 0) begin
                emitV = 1'b1;
                emitB = mVal;
            end
        end else begin
            if (mLen % SPB >= HALF) begin
                emitV = 1'b1;
                emitB = mVal;
            end else if (!mFirst && mLen < SPB) begin
                mExpGlitch = 1'b1;
            end
            mFirst = 1'b0;
            mVal   = s;
            mLen   = 1;
        end
        if (emitV) begin
            if (clr) begin
                mWbuf    = '0;
                mWbuf[0] = emitB;
                mWcount  = 1;
            end else begin
                mWbuf[mWcount] = emitB;
                mWcount++;
                if (mWcount == WW) begin
                    wordDone  = 1'b1;
                    mLastWord = mWbuf;
                    mWcount   = 0;
                end
            end
            e.b  = emitB;
            e.wv = wordDone;
            sb_q.push_back(e);
        end else if (clr || mExpGlitch) begin
            mWcount = 0;
        end
    endfunction

    task automatic monitorCycle(input logic r);
        ev_t e;
        if (bit_valid === 1'b1 && bit_out === 1'b1) onesSeen++;
        if (glitch === 1'b1) glitchSeen++;
        if (word_valid === 1'b1) wordsSeen++;
        if (r) begin
            checkOutput("rst_bit_valid", bit_valid, 0);
            checkOutput("rst_bit_out", bit_out, 0);
            checkOutput("rst_word_valid", word_valid, 0);
            checkOutput("rst_word_out", word_out, 0);
            checkOutput("rst_glitch", glitch, 0);
            return;
        end
        if (bit_valid !== 1'b0) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_bit_valid", bit_valid, 0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("bit_out", bit_out, e.b);
                checkOutput("word_valid", word_valid, e.wv);
            end
        end else if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checkOutput("missing_bit_valid", bit_valid, 1);
        end else if (word_valid !== 1'b0) begin
            checkOutput("stray_word_valid", word_valid, 0);
        end
        if (glitch !== 1'b0 || mExpGlitch) checkOutput("glitch", glitch, mExpGlitch);
        checkOutput("word_out", word_out, mLastWord);
    endtask

    task automatic applyStimulus(input logic d, input logic clr, input logic r);
        din      = d;
        word_clr = clr;
        rst      = r;
        @(posedge clk);
        modelEdge(d, clr, r);
        @(negedge clk);
        monitorCycle(r);
    endtask

    task automatic hold(input logic d, input int n);
        for (int i = 0; i < n; i++) applyStimulus(d, 1'b0, 1'b0);
    endtask

    task automatic sendBit(input logic b);
        hold(b, SPB);
    endtask

    // word_clr on the 2nd sample, the edge where the previous bit is emitted
    task automatic sendBitClr(input logic b);
        applyStimulus(b, 1'b0, 1'b0);
        applyStimulus(b, 1'b1, 1'b0);
        hold(b, SPB - 2);
    endtask

    task automatic sendByte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) sendBit(v[i]);
    endtask

    task automatic checkAfterRelease();
        checkOutput("post_rst_bit_valid", bit_valid, 0);
        checkOutput("post_rst_word_valid", word_valid, 0);
        checkOutput("post_rst_glitch", glitch, 0);
    endtask

    initial begin
        int o;
        int g;
        int w;
        int runLen[3];
        int runOnes[3];
        logic [9:0] cbits;
        runLen  = '{27, 24, 5};
        runOnes = '{3, 2, 1};
        cbits   = 10'b11_0100_1101;

        // reset with din toggling, then a first transition that must not glitch
        for (int i = 0; i < 6; i++) applyStimulus(logic'(i % 2), 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkAfterRelease();
        g = glitchSeen;
        hold(1'b1, 11);
        hold(1'b0, 20);
        checkOutput("first_transition_glitch", glitchSeen - g, 0);

        // single full-length high bit inside a low stream
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        hold(1'b0, 30);
        o = onesSeen;
        g = glitchSeen;
        hold(1'b1, 10);
        hold(1'b0, 25);
        checkOutput("single_bit_ones", onesSeen - o, 1);
        checkOutput("single_bit_glitch", glitchSeen - g, 0);

        // run-length rounding of high runs
        for (int k = 0; k < 3; k++) begin
            o = onesSeen;
            g = glitchSeen;
            hold(1'b1, runLen[k]);
            hold(1'b0, 30);
            checkOutput($sformatf("run%0d_ones", runLen[k]), onesSeen - o, runOnes[k]);
            checkOutput($sformatf("run%0d_glitch", runLen[k]), glitchSeen - g, 0);
        end

        // 0xA5 aligned by a clear on its first emit
        hold(1'b1, SPB);
        sendBitClr(1'b0);
        sendBit(1'b1); sendBit(1'b0); sendBit(1'b0);
        sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);

        // four bits of a new word, a 3-sample glitch, then a full word
        sendBit(1'b0);
        checkOutput("word_a5", word_out, 8'hA5);
        sendBit(1'b1); sendBit(1'b1); sendBit(1'b0);
        g = glitchSeen;
        w = wordsSeen;
        hold(1'b1, 3);
        sendByte(8'h36);
        hold(1'b0, 2);
        checkOutput("glitch_count", glitchSeen - g, 1);
        checkOutput("word_after_glitch", word_out, 8'h36);
        checkOutput("words_after_glitch", wordsSeen - w, 1);

        // clear coinciding with the 3rd bit's emit
        w = wordsSeen;
        sendBit(cbits[0]);
        sendBit(cbits[1]);
        sendBit(cbits[2]);
        sendBitClr(cbits[3]);
        for (int i = 4; i < 10; i++) sendBit(cbits[i]);
        hold(1'b0, 2);
        checkOutput("word_after_clr", word_out, 8'hD3);
        checkOutput("words_after_clr", wordsSeen - w, 1);

        // reset in the middle of a word and a run
        sendBit(1'b1); sendBit(1'b0);
        hold(1'b1, 4);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkAfterRelease();
        hold(1'b0, 3);
        hold(1'b1, 15);
        hold(1'b0, 10);
        checkOutput("word_out_after_reset", word_out, 0);
        checkOutput("scoreboard_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertsEvaluated, failures);
        $finish;
    end

endmodule
